data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Data-memory stage sitting directly downstream of the 64-bit ALU in the single-cycle CPU.
- Consumes the ALU result as a byte address and the rs2 value as store data.
- Performs RISC-V-style byte/half/word/double loads and stores, with sign or zero extension on loads.
- Flags misaligned, out-of-range and illegal accesses through a sticky fault register, and keeps load/store access counters.

Parameters:
- DEPTH_WORDS, 256, number of 64-bit words in the array; must be a power of two.
- CNT_W, 32, width of the saturating load and store counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  64  byte address, driven by ALU out.
- wdata  input  64  store data (rs2).
- mem_read  input  1  load request this cycle.
- mem_write  input  1  store request this cycle.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- fault_clr  input  1  clears the sticky fault and fault_addr.
- rdata  output  64  extended load result (combinational).
- misaligned  output  1  combinational: current access is misaligned.
- fault  output  1  sticky fault flag.
- fault_addr  output  64  address of the first fault since the last clear.
- load_cnt  output  CNT_W  number of completed legal loads.
- store_cnt  output  CNT_W  number of completed legal stores.

Behaviour:
- Reset (rst_n low, asynchronous):
  - fault=0, fault_addr=0, load_cnt=0, store_cnt=0.
  - rdata forced to 0 while rst_n is low.
  - Array contents are not reset.
- Addressing:
  - word index = addr[log2(DEPTH_WORDS)+2:3]; byte offset = addr[2:0].
  - Little-endian: byte k of a word sits at wdata[8k+7:8k].
- Size: B=1, H=2, W=4, D=8 bytes.
  - misaligned = (mem_read|mem_write) & (offset mod size != 0).
- out_of_range = addr >= DEPTH_WORDS*8 (full 64-bit compare, no wrap).
- illegal:
  - funct3=111 with any access.
  - funct3[2]=1 with mem_write.
- bad = misaligned | out_of_range | illegal.
- Loads (0-cycle latency, combinational):
  - rdata = selected bytes, sign-extended (000/001/010) or zero-extended (100/101/110); D returns the full word.
  - rdata = 0 when mem_read=0 or bad.
- Stores (1-cycle latency):
  - Write happens on the clk edge only when mem_write & !bad.
  - Only the size bytes at the offset are updated (byte-lane strobes); other bytes are preserved.
- mem_read & mem_write in the same cycle:
  - Store commits at the edge.
  - rdata shows pre-write contents that cycle (read-before-write).
  - Both counters increment if the access is legal.
- Fault capture, on the edge:
  - If bad & (mem_read|mem_write) and fault=0: fault<=1, fault_addr<=addr.
  - If fault already 1: fault_addr holds its value (first-fault wins).
  - fault_clr and a new bad access in the same cycle: the new fault is captured (fault=1, fault_addr=new addr).
  - fault_clr alone: fault<=0, fault_addr<=0.
- Counters:
  - +1 per legal load / legal store.
  - Saturate at all-ones; no wrap.
  - Faulting accesses are not counted.
- Reset asserted mid-store: the write is suppressed if rst_n is low at the edge.

Decomposition:
- Shared package cpu_pkg:
  - funct3 constants (F3_B…F3_WU).
  - Access-size enum.
  - Helper function size_bytes(funct3).
- One sub-module: load_store_lane. It is combinational and performs two jobs:
  - Generates the 8-bit byte strobe plus the shifted write data.
  - Extracts and extends load data.
- data_mem holds the array, fault logic and counters.

Test Plan:
- SD addr=0x10 wdata=0x1122334455667788, then LD addr=0x10 -> rdata=0x1122334455667788; store_cnt=1, load_cnt=1.
- SB addr=0x13 wdata=0xFF over that word, then LB 0x13 -> 0xFFFFFFFFFFFFFFFF; LBU 0x13 -> 0xFF; LD 0x10 -> 0x11223344FF667788.
- SW addr=0x22 -> misaligned=1, fault=1, fault_addr=0x22, no write, store_cnt unchanged. A later LH 0x31 leaves fault_addr=0x22.
- LD addr=0x800 with DEPTH_WORDS=256 -> rdata=0, fault=1, fault_addr=0x800. fault_clr together with SB funct3=100 at 0x8 -> fault=1, fault_addr=0x8.
- mem_read & mem_write, SD 0x18 value 0xAAAA over old 0x5555 -> same-cycle rdata=0x5555; next-cycle LD -> 0xAAAA.
- Drop rst_n asynchronously mid-cycle during an SD -> fault, counters and rdata are 0 immediately; after release, LD shows the old contents.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store funct3 encodings and access-size helpers.
package cpu_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord,
    SzDouble
  } access_size_e;

  // The low two funct3 bits encode log2 of the access size; bit 2 selects zero-extension.
  function automatic access_size_e access_size(input logic [2:0] funct3);
    access_size_e sz;
    case (funct3[1:0])
      2'b00:   sz = SzByte;
      2'b01:   sz = SzHalf;
      2'b10:   sz = SzWord;
      default: sz = SzDouble;
    endcase
    return sz;
  endfunction

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << access_size(funct3);
  endfunction

endpackage

// File: rtl/load_store_lane.sv
// Byte-lane steering between the 64-bit array word and the CPU-side data.
module load_store_lane
  import cpu_pkg::*;
(
  input  logic [2:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rword_i,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);

  logic [7:0]  size_mask;
  logic [5:0]  bit_sh;
  logic [63:0] rshift;

  assign bit_sh = {offset_i, 3'b000};

  // Store side: strobe the size bytes at the offset and move data onto those lanes.
  always_comb begin
    size_mask = 8'hff;
    case (access_size(funct3_i))
      SzByte:  size_mask = 8'h01;
      SzHalf:  size_mask = 8'h03;
      SzWord:  size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
    wstrb_o = size_mask << offset_i;
    wdata_o = wdata_i << bit_sh;
  end

  // Load side: bring the addressed bytes down to bit 0, then sign- or zero-extend.
  always_comb begin
    rshift  = rword_i >> bit_sh;
    rdata_o = rshift;
    case (funct3_i)
      F3_B:    rdata_o = {{56{rshift[7]}}, rshift[7:0]};
      F3_H:    rdata_o = {{48{rshift[15]}}, rshift[15:0]};
      F3_W:    rdata_o = {{32{rshift[31]}}, rshift[31:0]};
      F3_BU:   rdata_o = {56'd0, rshift[7:0]};
      F3_HU:   rdata_o = {48'd0, rshift[15:0]};
      F3_WU:   rdata_o = {32'd0, rshift[31:0]};
      default: rdata_o = rshift;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Data-memory stage: word array with byte-lane stores, combinational loads,
// sticky first-fault capture and saturating legal-access counters.
module data_mem
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      addr,
  input  logic [63:0]      wdata,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic             fault_clr,
  output logic [63:0]      rdata,
  output logic             misaligned,
  output logic             fault,
  output logic [63:0]      fault_addr,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam logic [63:0] ByteLimit = 64'(DEPTH_WORDS) * 64'd8;

  logic [63:0] mem_q [DEPTH_WORDS];

  logic [IdxW-1:0]  word_idx;
  logic [2:0]       offset;
  logic [3:0]       size_m1;
  logic             access, out_of_range, illegal, bad;
  logic             load_ok, store_ok;
  logic [7:0]       wstrb;
  logic [63:0]      lane_wdata, lane_rdata;
  logic             fault_d, fault_q;
  logic [63:0]      fault_addr_d, fault_addr_q;
  logic [CNT_W-1:0] load_cnt_d, load_cnt_q, store_cnt_d, store_cnt_q;

  assign word_idx     = addr[IdxW+2:3];
  assign offset       = addr[2:0];
  assign size_m1      = size_bytes(funct3) - 4'd1;
  assign access       = mem_read | mem_write;
  assign misaligned   = access & ((offset & size_m1[2:0]) != 3'd0);
  assign out_of_range = addr >= ByteLimit;
  assign illegal      = access & ((funct3 == F3_BAD) | (funct3[2] & mem_write));
  assign bad          = misaligned | out_of_range | illegal;
  assign load_ok      = mem_read & ~bad;
  assign store_ok     = mem_write & ~bad;

  load_store_lane u_lane (
    .offset_i (offset),
    .funct3_i (funct3),
    .wdata_i  (wdata),
    .rword_i  (mem_q[word_idx]),
    .wstrb_o  (wstrb),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  // Load result: zero unless a legal load is in progress outside reset.
  always_comb begin
    rdata = 64'd0;
    if (rst_n && load_ok) begin
      rdata = lane_rdata;
    end
  end

  // Array write; contents deliberately survive reset, but a store is dropped while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (store_ok) begin
      for (int k = 0; k < 8; k++) begin
        if (wstrb[k]) begin
          mem_q[word_idx][8*k +: 8] <= lane_wdata[8*k +: 8];
        end
      end
    end
  end

  // Next-state for first-fault capture and saturating counters.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    load_cnt_d   = load_cnt_q;
    store_cnt_d  = store_cnt_q;
    if (access && bad) begin
      // A clear in the same cycle re-arms capture, so the new fault wins.
      if (!fault_q || fault_clr) begin
        fault_d      = 1'b1;
        fault_addr_d = addr;
      end
    end else if (fault_clr) begin
      fault_d      = 1'b0;
      fault_addr_d = 64'd0;
    end
    if (load_ok && (load_cnt_q != '1)) begin
      load_cnt_d = load_cnt_q + CNT_W'(1);
    end
    if (store_ok && (store_cnt_q != '1)) begin
      store_cnt_d = store_cnt_q + CNT_W'(1);
    end
  end

  // Fault and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 64'd0;
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
    end
  end

  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
  assign load_cnt   = load_cnt_q;
  assign store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios followed by randomized
// accesses compared against a byte-addressed reference memory.
module tb_data_mem;

  localparam int unsigned Depth = 256;
  localparam int unsigned CntW  = 6;
  localparam int unsigned NB    = Depth * 8;
  localparam int unsigned CMax  = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [63:0]     addr = '0;
  logic [63:0]     wdata = '0;
  logic            mem_read = 1'b0;
  logic            mem_write = 1'b0;
  logic [2:0]      funct3 = '0;
  logic            fault_clr = 1'b0;
  logic [63:0]     rdata;
  logic            misaligned;
  logic            fault;
  logic [63:0]     fault_addr;
  logic [CntW-1:0] load_cnt;
  logic [CntW-1:0] store_cnt;

  data_mem #(
    .DEPTH_WORDS (Depth),
    .CNT_W       (CntW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .wdata      (wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .fault_clr  (fault_clr),
    .rdata      (rdata),
    .misaligned (misaligned),
    .fault      (fault),
    .fault_addr (fault_addr),
    .load_cnt   (load_cnt),
    .store_cnt  (store_cnt)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [7:0]  ref_mem [NB];
  logic        ref_fault = 1'b0;
  logic [63:0] ref_faddr = '0;
  int unsigned ref_ld = 0;
  int unsigned ref_st = 0;
  logic [63:0] last_rdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic bit is_bad(input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [63:0] a);
    if (!(rd || wr)) return 1'b0;
    if (f3 == 3'b111) return 1'b1;
    if (f3[2] && wr) return 1'b1;
    if (a >= 64'(NB)) return 1'b1;
    if ((a % 64'(acc_size(f3))) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
    int unsigned n = acc_size(f3);
    int unsigned base = int'(a[$clog2(NB)-1:0]);
    logic [63:0] v = '0;
    for (int i = 0; i < int'(n); i++) v[8*i +: 8] = ref_mem[base + i];
    if (!f3[2] && n < 8 && v[8*n-1]) begin
      for (int i = 8 * int'(n); i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_reset();
    ref_fault = 1'b0;
    ref_faddr = '0;
    ref_ld    = 0;
    ref_st    = 0;
  endtask

  // One access cycle: called just after a rising edge; checks combinational outputs,
  // steps through the edge, updates the model, then checks registered outputs.
  task automatic acc(input bit rd, input bit wr, input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] wd, input bit clr, input string tag);
    bit bad;
    logic [63:0] exp_rd;
    int unsigned base;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; fault_clr = clr;
    #1;
    bad    = is_bad(rd, wr, f3, a);
    exp_rd = (rd && !bad) ? ref_load(f3, a) : 64'd0;
    last_rdata = rdata;
    check({tag, " rdata"}, rdata, exp_rd);
    if (f3 != 3'b111) begin
      check({tag, " misaligned"}, 64'(misaligned),
            64'((rd || wr) && ((a % 64'(acc_size(f3))) != 0)));
    end
    @(posedge clk);
    #1;
    if (wr && !bad) begin
      base = int'(a[$clog2(NB)-1:0]);
      for (int i = 0; i < int'(acc_size(f3)); i++) ref_mem[base + i] = wd[8*i +: 8];
    end
    if (rd && !bad && ref_ld < CMax) ref_ld++;
    if (wr && !bad && ref_st < CMax) ref_st++;
    if ((rd || wr) && bad) begin
      if (!ref_fault || clr) begin
        ref_fault = 1'b1;
        ref_faddr = a;
      end
    end else if (clr) begin
      ref_fault = 1'b0;
      ref_faddr = '0;
    end
    check({tag, " fault"}, 64'(fault), 64'(ref_fault));
    check({tag, " fault_addr"}, fault_addr, ref_faddr);
    check({tag, " load_cnt"}, 64'(load_cnt), 64'(ref_ld));
    check({tag, " store_cnt"}, 64'(store_cnt), 64'(ref_st));
    mem_read = 1'b0; mem_write = 1'b0; fault_clr = 1'b0;
  endtask

  initial begin
    bit          rd, wr, clr;
    logic [2:0]  f3;
    logic [63:0] a, wd;
    int unsigned r;

    // Reset state, with a load requested to show rdata is forced low.
    mem_read = 1'b1; funct3 = 3'b011; addr = 64'h10;
    #12;
    check("reset rdata", rdata, 64'd0);
    check("reset fault", 64'(fault), 64'd0);
    check("reset fault_addr", fault_addr, 64'd0);
    check("reset load_cnt", 64'(load_cnt), 64'd0);
    check("reset store_cnt", 64'(store_cnt), 64'd0);
    mem_read = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Doubleword round trip.
    acc(0, 1, 3'b011, 64'h10, 64'h1122334455667788, 0, "sd10");
    acc(1, 0, 3'b011, 64'h10, 64'd0, 0, "ld10");
    check("ld10 value", last_rdata, 64'h1122334455667788);
    check("ld10 counts", {32'(load_cnt), 32'(store_cnt)}, {32'd1, 32'd1});

    // Byte store then signed/unsigned byte loads and merged word.
    acc(0, 1, 3'b000, 64'h13, 64'hFF, 0, "sb13");
    acc(1, 0, 3'b000, 64'h13, 64'd0, 0, "lb13");
    check("lb13 value", last_rdata, 64'hFFFFFFFFFFFFFFFF);
    acc(1, 0, 3'b100, 64'h13, 64'd0, 0, "lbu13");
    check("lbu13 value", last_rdata, 64'hFF);
    acc(1, 0, 3'b011, 64'h10, 64'd0, 0, "ld10b");
    check("ld10b value", last_rdata, 64'h11223344FF667788);

    // Misaligned store faults; a later fault keeps the first address.
    acc(0, 1, 3'b010, 64'h22, 64'hDEAD, 0, "sw22");
    acc(1, 0, 3'b001, 64'h31, 64'd0, 0, "lh31");
    check("first fault wins", fault_addr, 64'h22);

    // Out of range, then clear combined with an illegal store.
    acc(0, 0, 3'b000, 64'h0, 64'd0, 1, "clr");
    acc(1, 0, 3'b011, 64'h800, 64'd0, 0, "ld800");
    acc(0, 1, 3'b100, 64'h8, 64'h77, 1, "clr+sbu8");
    check("clr+new fault addr", fault_addr, 64'h8);

    // Read-before-write on a simultaneous load/store.
    acc(0, 0, 3'b000, 64'h0, 64'd0, 1, "clr2");
    acc(0, 1, 3'b011, 64'h18, 64'h5555, 0, "sd18a");
    acc(1, 1, 3'b011, 64'h18, 64'hAAAA, 0, "rw18");
    check("rw18 old value", last_rdata, 64'h5555);
    acc(1, 0, 3'b011, 64'h18, 64'd0, 0, "ld18");
    check("ld18 new value", last_rdata, 64'hAAAA);

    // Asynchronous reset in the middle of a store.
    acc(1, 0, 3'b010, 64'h801, 64'd0, 0, "prefault");
    mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b011; addr = 64'h18; wdata = 64'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst fault", 64'(fault), 64'd0);
    check("async rst fault_addr", fault_addr, 64'd0);
    check("async rst counts", {32'(load_cnt), 32'(store_cnt)}, 64'd0);
    check("async rst rdata", rdata, 64'd0);
    @(posedge clk);
    #2;
    mem_read = 1'b0; mem_write = 1'b0;
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    acc(1, 0, 3'b011, 64'h18, 64'd0, 0, "ld18 after rst");
    check("store suppressed in reset", last_rdata, 64'hAAAA);

    // Fill the whole array so every later load has a known reference.
    for (int w = 0; w < int'(Depth); w++) begin
      acc(0, 1, 3'b011, 64'(w * 8), {$urandom, $urandom}, 0, "fill");
    end
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Randomized traffic including boundary and wild addresses.
    for (int n = 0; n < 1500; n++) begin
      r   = $urandom_range(0, 3);
      rd  = r[0];
      wr  = r[1];
      f3  = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 7) == 0);
      wd  = {$urandom, $urandom};
      r   = $urandom_range(0, 15);
      if (r == 0) begin
        a = {$urandom, $urandom};
      end else if (r == 1) begin
        a = 64'(NB) - 64'd8 + 64'($urandom_range(0, 15));
      end else begin
        a = 64'($urandom_range(0, NB - 1));
        if (r > 4) a = a & ~(64'(acc_size(f3)) - 64'd1);
      end
      acc(rd, wr, f3, a, wd, clr, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
